// File: rtl/instaweb_pkg.sv
// ============================================================================
// Module   : instaweb_pkg
// Brief    : Shared header layout, FSM state encoding and stat widths for the
//            instaweb link ingress.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package instaweb_pkg;

    localparam int HDR_TGT_LSB      = 0;
    localparam int COORD_WIDTH_DFLT = 24;
    localparam int HDR_LEN_LSB      = HDR_TGT_LSB + COORD_WIDTH_DFLT;
    localparam int LEN_WIDTH_DFLT   = 4;
    localparam int STAT_WIDTH       = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } ingress_state_t;

endpackage

`default_nettype wire

// File: rtl/instaweb_beat_fifo.sv
// ============================================================================
// Module   : instaweb_beat_fifo
// Brief    : Synchronous FIFO with occupancy, full and empty; zero on empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instaweb_beat_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_count;
    assign o_full    = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    // A pop frees the slot this cycle, so push-at-full is legal alongside it.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/instaweb_link_ingress.sv
// ============================================================================
// Module   : instaweb_link_ingress
// Brief    : Link receive endpoint: frames beats, tags local/relay, buffers
//            whole frames and drops frames that cannot fit. Optional frame
//            statistics under INSTAWEB_INGRESS_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instaweb_link_ingress
    import instaweb_pkg::*;
#(
    parameter int DATA_WIDTH  = 512,
    parameter int COORD_WIDTH = 24,
    parameter int LEN_WIDTH   = LEN_WIDTH_DFLT,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic                   clk_synce,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  link_rx_data,
    input  logic                   link_rx_valid,
    input  logic [COORD_WIDTH-1:0] my_coord,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_last,
    output logic                   m_local,
    output logic [STAT_WIDTH-1:0]  frames_accepted,
    output logic [STAT_WIDTH-1:0]  frames_dropped
);

    localparam int c_occ_w   = $clog2(FIFO_DEPTH) + 1;
    localparam int c_len_lsb = HDR_TGT_LSB + COORD_WIDTH;

    ingress_state_t       r_state;
    logic [LEN_WIDTH-1:0] r_cnt;
    logic                 r_local;

    logic [LEN_WIDTH-1:0]    w_hdr_len;
    logic                    w_hdr_hit;
    logic                    w_is_hdr;
    logic                    w_fits;
    logic                    w_hdr_accept;
    logic [c_occ_w-1:0]      w_occ;
    logic [c_occ_w-1:0]      w_free;
    logic [c_occ_w-1:0]      w_need;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_last;
    logic                    w_local;
    logic [DATA_WIDTH+1:0]   w_fifo_dout;

    assign w_hdr_len = link_rx_data[c_len_lsb +: LEN_WIDTH];
    assign w_hdr_hit = (link_rx_data[HDR_TGT_LSB +: COORD_WIDTH] == my_coord);
    assign w_is_hdr  = (r_state == ST_IDLE) && link_rx_valid;

    // Admission reserves room for the whole frame against registered
    // occupancy; a pop in the same cycle is deliberately not credited.
    assign w_free       = c_occ_w'(FIFO_DEPTH) - w_occ;
    assign w_need       = c_occ_w'(w_hdr_len) + c_occ_w'(1);
    assign w_fits       = !w_full && (w_free >= w_need);
    assign w_hdr_accept = w_is_hdr && w_fits;

    always_comb begin
        w_push  = 1'b0;
        w_last  = 1'b0;
        w_local = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_push  = w_hdr_accept;
                w_last  = (w_hdr_len == '0);
                w_local = w_hdr_hit;
            end
            ST_PAYLOAD: begin
                w_push  = link_rx_valid;
                w_last  = (r_cnt == LEN_WIDTH'(1));
                w_local = r_local;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_synce or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_local <= 1'b0;
        end else if (link_rx_valid) begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt   <= w_hdr_len;
                    r_local <= w_hdr_hit;
                    if (w_hdr_len != '0)
                        r_state <= w_fits ? ST_PAYLOAD : ST_DROP;
                end
                ST_PAYLOAD, ST_DROP: begin
                    r_cnt <= r_cnt - LEN_WIDTH'(1);
                    if (r_cnt == LEN_WIDTH'(1))
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    instaweb_beat_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_synce),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({link_rx_data, w_last, w_local}),
        .i_pop   (m_ready),
        .o_data  (w_fifo_dout),
        .o_count (w_occ),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign {m_data, m_last, m_local} = w_fifo_dout;
    assign m_valid = !w_empty;

`ifdef INSTAWEB_INGRESS_STATS_EN
    logic                  w_hdr_drop;
    logic [STAT_WIDTH-1:0] r_frames_accepted;
    logic [STAT_WIDTH-1:0] r_frames_dropped;

    assign w_hdr_drop = w_is_hdr && !w_fits;

    always_ff @(posedge clk_synce or posedge rst) begin
        if (rst) begin
            r_frames_accepted <= '0;
            r_frames_dropped  <= '0;
        end else begin
            if (w_hdr_accept && (r_frames_accepted != '1))
                r_frames_accepted <= r_frames_accepted + STAT_WIDTH'(1);
            if (w_hdr_drop && (r_frames_dropped != '1))
                r_frames_dropped <= r_frames_dropped + STAT_WIDTH'(1);
        end
    end

    assign frames_accepted = r_frames_accepted;
    assign frames_dropped  = r_frames_dropped;
`else
    assign frames_accepted = '0;
    assign frames_dropped  = '0;
`endif

endmodule

`default_nettype wire
